// File: rtl/raccoon_master32.sv
// Single-outstanding 32-bit Raccoon ring master: CPU request -> ring packet -> response strobe.
// Optional response timeout is compiled in with `define RACCOON_MASTER_TIMEOUT_EN.
module raccoon_master32 #(
  parameter logic [3:0]  MASTER_ID      = 4'h1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] RaccIn,
  output logic [63:0] RaccOut,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_WMASK,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state_q;
  logic [63:0] din_q;
  logic [63:0] raccout_q;
  logic [63:0] pkt_q;
  logic [3:0]  tag_q;
  logic [3:0]  cur_tag_q;
  logic        armed_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        unused_ok;

  logic din_busy;
  logic din_own;
  logic din_cur;
  logic din_stale;

  // Own packets are only "current" while a transaction is outstanding; anything else of ours is stale.
  assign din_busy  = din_q[63];
  assign din_own   = din_busy && (din_q[61:58] == MASTER_ID);
  assign din_cur   = din_own && (din_q[57:54] == cur_tag_q) && (state_q != IDLE);
  assign din_stale = din_own && !din_cur;

`ifdef RACCOON_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign unused_ok = ^{REQ_ADDR[31:20], REQ_ADDR[1:0]};
`else
  assign unused_ok = ^{REQ_ADDR[31:20], REQ_ADDR[1:0], TIMEOUT_CYCLES};
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      din_q       <= '0;
      raccout_q   <= '0;
      pkt_q       <= '0;
      tag_q       <= '0;
      cur_tag_q   <= '0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef RACCOON_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      din_q       <= RaccIn;
      raccout_q   <= din_stale ? 64'd0 : din_q;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ_VALID && ready_q) begin
            pkt_q     <= {2'b11, MASTER_ID, tag_q, REQ_WMASK, REQ_ADDR[19:2], REQ_WDATA};
            cur_tag_q <= tag_q;
            tag_q     <= tag_q + 4'd1;
            armed_q   <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          // First SEND cycle only arms, so the packet leaves two edges after acceptance.
          if (!armed_q) begin
            armed_q <= 1'b1;
          end else if (!din_busy || din_stale) begin
            raccout_q <= pkt_q;
            state_q   <= WAIT;
`ifdef RACCOON_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        WAIT: begin
          if (din_cur) begin
            raccout_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= din_q[62];
            rsp_rdata_q <= din_q[62] ? 32'd0 : din_q[31:0];
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
`ifdef RACCOON_MASTER_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RaccOut   = raccout_q;
  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_raccoon_master32.sv
// Directed bench for raccoon_master32: ring slave model, loopback, foreign/stale traffic, timeout, reset.
// Expected responses are queued at request time and popped whenever RSP_VALID is seen.
module tb_raccoon_master32;

  logic        CLK;
  logic        RST;
  logic [63:0] RaccIn;
  logic [63:0] RaccOut;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [3:0]  REQ_WMASK;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  int          errs = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  logic        got_rsp;
  logic [3:0]  exp_tag;
  logic [1:0]  mode;
  logic [63:0] drv;
  logic [63:0] slave_out;
  logic [31:0] mem [16];

  raccoon_master32 #(.MASTER_ID(4'h1), .TIMEOUT_CYCLES(16'd8)) dut (
    .CLK(CLK), .RST(RST), .RaccIn(RaccIn), .RaccOut(RaccOut),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WMASK(REQ_WMASK),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // mode 0: bench drives the ring, 1: RaccOut looped back, 2: through the slave model
  assign RaccIn = (mode == 2'd0) ? drv : (mode == 2'd1) ? RaccOut : slave_out;

  // Slave node for word addresses 0x4000-0x7FFF (byte 0x10000-0x1FFFF), one-cycle latency
  always_ff @(posedge CLK) begin
    if (!RST) begin
      slave_out <= '0;
    end else if (RaccOut[63:62] == 2'b11 && RaccOut[49:46] == 4'b0001) begin
      for (int b = 0; b < 4; b++)
        if (RaccOut[50+b]) mem[RaccOut[35:32]][8*b +: 8] <= RaccOut[8*b +: 8];
      slave_out <= {2'b10, RaccOut[61:54], 4'h0, RaccOut[49:32],
                    (RaccOut[53:50] != 4'h0) ? 32'd0 : mem[RaccOut[35:32]]};
    end else begin
      slave_out <= RaccOut;
    end
  end

  function automatic logic [63:0] mkreq(input logic [3:0] tag, input logic [3:0] m,
                                        input logic [31:0] a, input logic [31:0] d);
    return {2'b11, 4'h1, tag, m, a[19:2], d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock; any response strobe is checked against the scoreboard head
  task automatic tick();
    @(posedge CLK);
    #1;
    if (RSP_VALID === 1'b1) begin
      got_rsp = 1'b1;
      if (exp_q.size() == 0) chk("unexpected_rsp", {31'd0, RSP_RDATA, RSP_ERR}, 64'd0);
      else chk("rsp", {31'd0, RSP_RDATA, RSP_ERR}, {31'd0, exp_q.pop_front()});
    end
  endtask

  task automatic wait_rsp(input int budget);
    got_rsp = 1'b0;
    for (int i = 0; i < budget && !got_rsp; i++) tick();
    chk("rsp_seen", {63'd0, got_rsp}, 64'd1);
  endtask

  task automatic submit(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    REQ_VALID = 1'b1; REQ_WMASK = m; REQ_ADDR = a; REQ_WDATA = d;
    chk("req_ready_idle", {63'd0, REQ_READY}, 64'd1);
    tick();
    REQ_VALID = 1'b0;
    exp_tag = exp_tag + 4'd1;
  endtask

  task automatic wait_ins(input logic [63:0] pkt);
    for (int i = 0; i < 8 && RaccOut !== pkt; i++) tick();
    chk("insert", RaccOut, pkt);
  endtask

  initial begin
    int k;
    logic [63:0] p;
    RST = 1'b0; REQ_VALID = 1'b0; REQ_WMASK = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    drv = '0; mode = 2'd0; exp_tag = 4'd0; got_rsp = 1'b0;
    tick(); tick();
    chk("reset_raccout", RaccOut, 64'd0);
    chk("reset_rsp_valid", {63'd0, RSP_VALID}, 64'd0);
    chk("reset_ready", {63'd0, REQ_READY}, 64'd1);
    RST = 1'b1;
    tick();

    // 1: write then read through the slave
    mode = 2'd2;
    exp_q.push_back({32'd0, 1'b0});
    submit(4'hF, 32'h0001_0004, 32'hCAFE_F00D);
    wait_rsp(40);
    exp_q.push_back({32'hCAFE_F00D, 1'b0});
    submit(4'h0, 32'h0001_0004, 32'd0);
    wait_rsp(40);
    chk("slot_freed", RaccOut, 64'd0);
    tick(); tick();

    // 2: loopback, unclaimed request returns as error
    mode = 2'd1;
    exp_q.push_back({32'd0, 1'b1});
    submit(4'h0, 32'h0002_0000, 32'd0);
    wait_rsp(40);
    tick(); tick();

    // 3: foreign traffic forwarded unchanged, packet waits for the first empty slot
    mode = 2'd0;
    REQ_VALID = 1'b1; REQ_WMASK = 4'h0; REQ_ADDR = 32'h0003_0010; REQ_WDATA = 32'd0;
    for (int i = 0; i < 5; i++) begin
      drv = {2'b11, 8'h20, 4'h3, 18'(i + 7), 32'(32'hF00 + i)};
      tick();
      REQ_VALID = 1'b0;
      chk("ready_low_fwd", {63'd0, REQ_READY}, 64'd0);
      if (i > 0) chk("fwd", RaccOut, {2'b11, 8'h20, 4'h3, 18'(i + 6), 32'(32'hF00 + i - 1)});
    end
    exp_tag = exp_tag + 4'd1;
    drv = '0;
    tick();
    chk("fwd_last", RaccOut, {2'b11, 8'h20, 4'h3, 18'd11, 32'hF04});
    tick();
    chk("insert_first_free", RaccOut, mkreq(exp_tag - 4'd1, 4'h0, 32'h0003_0010, 32'd0));
    drv = {2'b10, 4'h1, exp_tag - 4'd1, 4'h0, 18'd0, 32'h1234_5678};
    exp_q.push_back({32'h1234_5678, 1'b0});
    tick();
    drv = '0;
    wait_rsp(10);

    // 4: stale response removed silently, then the real one
    submit(4'h0, 32'h0001_0040, 32'd0);
    wait_ins(mkreq(exp_tag - 4'd1, 4'h0, 32'h0001_0040, 32'd0));
    drv = {2'b10, 4'h1, exp_tag - 4'd2, 4'h0, 18'd0, 32'hDEAD_BEEF};
    tick();
    drv = '0;
    got_rsp = 1'b0;
    tick();
    chk("stale_removed", RaccOut, 64'd0);
    chk("stale_no_rsp", {63'd0, got_rsp}, 64'd0);
    drv = {2'b10, 4'h1, exp_tag - 4'd1, 4'h0, 18'd0, 32'h55AA_55AA};
    exp_q.push_back({32'h55AA_55AA, 1'b0});
    tick();
    drv = '0;
    wait_rsp(10);
    tick();
    chk("rsp_one_cycle", {63'd0, RSP_VALID}, 64'd0);

    // 5: dropped request
    submit(4'h0, 32'h0001_0080, 32'd0);
    p = mkreq(exp_tag - 4'd1, 4'h0, 32'h0001_0080, 32'd0);
    wait_ins(p);
`ifdef RACCOON_MASTER_TIMEOUT_EN
    exp_q.push_back({32'd0, 1'b1});
    got_rsp = 1'b0;
    k = 0;
    while (!got_rsp && k < 30) begin
      tick();
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'd8);
`else
    got_rsp = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    chk("no_rsp_1000", {63'd0, got_rsp}, 64'd0);
    drv = {2'b10, 4'h1, exp_tag - 4'd1, 4'h0, 18'd0, 32'h0000_0777};
    exp_q.push_back({32'h0000_0777, 1'b0});
    tick();
    drv = '0;
    wait_rsp(10);
`endif
    tick(); tick();

    // 6: reset while waiting
    submit(4'h0, 32'h0001_00C0, 32'd0);
    wait_ins(mkreq(exp_tag - 4'd1, 4'h0, 32'h0001_00C0, 32'd0));
    RST = 1'b0;
    tick();
    RST = 1'b1;
    exp_q.delete();
    exp_tag = 4'd0;
    chk("rst_raccout", RaccOut, 64'd0);
    chk("rst_rsp_valid", {63'd0, RSP_VALID}, 64'd0);
    chk("rst_ready", {63'd0, REQ_READY}, 64'd1);
    submit(4'h0, 32'h0001_0100, 32'd0);
    wait_ins(mkreq(4'd0, 4'h0, 32'h0001_0100, 32'd0));
    drv = {2'b10, 4'h1, 4'd0, 4'h0, 18'd0, 32'h0BAD_CAFE};
    exp_q.push_back({32'h0BAD_CAFE, 1'b0});
    tick();
    drv = '0;
    wait_rsp(10);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
